multicycle_control: RTL and testbench

Main control unit for the multicycle RISC-V datapath: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back for `ld`, `sd`, R-type and `beq`. It emits the 2-bit `alu_op` class code consumed by the ALU-control decoder, plus all datapath enables and mux selects. A `mem_ready` handshake stretches the memory states.

---
 rtl/riscv_ctrl_pkg.sv | 31 +++
 rtl/multicycle_control.sv | 133 +++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// supported opcodes, ALU-class codes and ALU B-operand selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET_IDLE = 4'd0,
    ST_FETCH      = 4'd1,
    ST_DECODE     = 4'd2,
    ST_MEM_ADDR   = 4'd3,
    ST_MEM_READ   = 4'd4,
    ST_MEM_WB     = 4'd5,
    ST_MEM_WRITE  = 4'd6,
    ST_EXECUTE    = 4'd7,
    ST_ALU_WB     = 4'd8,
    ST_BRANCH     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (ld, sd, R-type, beq).
// Outputs decode from the state register; ir_write/pc_write/illegal_instr also see inputs.
//
// state         | meaning
// RESET_IDLE  0 | out of reset, all controls idle
// FETCH       1 | read instruction at PC, PC+4 via ALU, wait for mem_ready
// DECODE      2 | latch opcode, branch target into ALUOut
// MEM_ADDR    3 | rs1 + imm for ld/sd
// MEM_READ    4 | data read at ALUOut, wait for mem_ready
// MEM_WB      5 | MDR into register file
// MEM_WRITE   6 | data write at ALUOut, wait for mem_ready
// EXECUTE     7 | R-type ALU operation
// ALU_WB      8 | ALUOut into register file
// BRANCH      9 | compare rs1/rs2, conditional PC load from ALUOut
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic [3:0] state
);

  state_t     r_state;
  logic [6:0] r_opcode;
  logic       w_legal;

  assign w_legal = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                   (opcode == OP_RTYPE) || (opcode == OP_BRANCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RESET_IDLE;
      r_opcode <= '0;
    end else begin
      if (r_state == ST_DECODE) r_opcode <= opcode;
      case (r_state)
        ST_RESET_IDLE: r_state <= ST_FETCH;
        ST_FETCH:      if (mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: r_state <= ST_MEM_ADDR;
            OP_RTYPE:          r_state <= ST_EXECUTE;
            OP_BRANCH:         r_state <= ST_BRANCH;
            default:           r_state <= ST_FETCH;
          endcase
        end
        // live opcode may already have moved on; steer by the DECODE-time copy
        ST_MEM_ADDR:  r_state <= (r_opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  if (mem_ready) r_state <= ST_MEM_WB;
        ST_MEM_WB:    r_state <= ST_FETCH;
        ST_MEM_WRITE: if (mem_ready) r_state <= ST_FETCH;
        ST_EXECUTE:   r_state <= ST_ALU_WB;
        ST_ALU_WB:    r_state <= ST_FETCH;
        ST_BRANCH:    r_state <= ST_FETCH;
        default:      r_state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b     = SRCB_IMM;
        illegal_instr = ~w_legal;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: an instruction-level model expands
// each issued instruction into its expected per-cycle control vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, alu_src_a, illegal_instr;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int async_req  = 0;
  int async_done = 0;

  logic [18:0] exp_q[$];

  localparam int K_LD = 0, K_SD = 1, K_RT = 2, K_BEQ = 3, K_ILL = 4;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input int st, input bit pcw, input bit pwc,
                                     input bit psrc, input bit iod, input bit mr,
                                     input bit mw, input bit irw, input bit m2r,
                                     input bit rw, input bit sa, input logic [1:0] sb,
                                     input logic [1:0] aop, input bit ill);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, pcw, pwc, psrc, iod, mr, mw, irw, m2r, rw, sa, sb, aop, ill};
  endfunction

  function automatic logic [18:0] actual();
    return {state, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
            ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_instr};
  endfunction

  function automatic logic [6:0] opcode_of(input int kind);
    logic [6:0] op;
    case (kind)
      K_LD:    op = 7'b0000011;
      K_SD:    op = 7'b0100011;
      K_RT:    op = 7'b0110011;
      K_BEQ:   op = 7'b1100011;
      default: begin
        do op = 7'($urandom_range(0, 127));
        while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b1100011);
      end
    endcase
    return op;
  endfunction

  // Monitor: one expected vector per cycle; also checks the async-reset snapshot.
  initial begin
    logic [18:0] e, a;
    forever begin
      @(negedge clk or negedge rst_n);
      if (async_req != async_done) begin
        #1;
        a = actual();
        n_checks++;
        if (a === 19'h0) n_pass++;
        else $display("FAIL async_reset t=%0t actual=%h required=%h", $time, a, 19'h0);
        async_done = async_req;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cycle t=%0t actual=%h required=%h (state act=%0d req=%0d)",
                      $time, a, e, a[18:15], e[18:15]);
      end
    end
  end

  task automatic cyc(input logic mr, input logic [6:0] op, input logic [18:0] e);
    mem_ready = mr;
    opcode    = op;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic junk_mr();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] junk_op();
    return 7'($urandom_range(0, 127));
  endfunction

  // Issues one instruction; abort_rd=1 drops rst_n mid-cycle in the first MEM_READ cycle.
  task automatic do_instr(input int kind, input int wf, input int wm, input bit abort_rd = 0);
    logic [6:0] op;
    op = opcode_of(kind);
    for (int i = 0; i < wf; i++)
      cyc(1'b0, junk_op(), mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
    cyc(1'b1, junk_op(), mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0));
    cyc(junk_mr(), op, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, kind == K_ILL));
    case (kind)
      K_LD, K_SD: begin
        cyc(junk_mr(), junk_op(), mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0));
        if (kind == K_LD) begin
          if (abort_rd) begin
            mem_ready = 1'b0;
            opcode    = junk_op();
            exp_q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            @(negedge clk);
            #2;
            async_req++;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            return;
          end
          for (int i = 0; i < wm; i++)
            cyc(1'b0, junk_op(), mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
          cyc(1'b1, junk_op(), mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
          cyc(junk_mr(), junk_op(), mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
        end else begin
          for (int i = 0; i < wm; i++)
            cyc(1'b0, junk_op(), mk(6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
          cyc(1'b1, junk_op(), mk(6, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        end
      end
      K_RT: begin
        cyc(junk_mr(), junk_op(), mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0));
        cyc(junk_mr(), junk_op(), mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0));
      end
      K_BEQ:
        cyc(junk_mr(), junk_op(), mk(9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0));
      default: ;
    endcase
  endtask

  task automatic reset_seq(input int hold);
    rst_n = 1'b0;
    for (int i = 0; i < hold; i++) cyc(junk_mr(), junk_op(), 19'h0);
    rst_n = 1'b1;
    cyc(junk_mr(), junk_op(), 19'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_seq(2);
    do_instr(K_LD, 0, 0);
    do_instr(K_RT, 0, 0);
    do_instr(K_BEQ, 0, 0);
    do_instr(K_SD, 0, 0);
    do_instr(K_LD, 3, 3);
    do_instr(K_SD, 2, 1);
    opcode = 7'b1111111;
    do_instr(K_ILL, 0, 0);
    do_instr(K_LD, 1, 0, 1'b1);
    reset_seq(1);
    do_instr(K_RT, 0, 0);
    for (int n = 0; n < 60; n++)
      do_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    @(negedge clk);
    #2;
    if (exp_q.size() != 0)
      $display("FAIL drain t=%0t actual=%0d required=0", $time, exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
